// File: rtl/e203_subsys_rst_seq.sv
// e203_subsys_rst_seq: staged bus-then-core reset release with reset-cause capture
module e203_subsys_rst_seq #(
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_GAP = 4,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       test_mode,
    input  logic       wdog_rst_req,
    input  logic       ndm_rst_req,
    input  logic       sw_rst_req,
    output logic       bus_rst_n,
    output logic       core_rst_n,
    output logic [1:0] rst_cause,
    output logic       rst_busy
);
    typedef enum logic [1:0] {HOLD, BUS_REL, RUN} state_t;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             bus_q, core_q, busy_q, bus_nxt, core_nxt, req;
    logic [1:0]       cause_q;
    assign req = wdog_rst_req | ndm_rst_req | sw_rst_req;
    // a request on the expiry edge wins, so it is tested before the counter compare
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bus_nxt   = bus_q;
        core_nxt  = core_q;
        case (state)
            HOLD:
                if (req) cnt_nxt = '0;
                else if (cnt == HOLD_LAST) begin
                    state_nxt = BUS_REL;
                    cnt_nxt   = '0;
                    bus_nxt   = 1'b1;
                end else cnt_nxt = cnt + 1'b1;
            BUS_REL:
                if (req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    bus_nxt   = 1'b0;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    core_nxt  = 1'b1;
                end else cnt_nxt = cnt + 1'b1;
            RUN:
                if (req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    bus_nxt   = 1'b0;
                    core_nxt  = 1'b0;
                end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
                bus_nxt   = 1'b0;
                core_nxt  = 1'b0;
            end
        endcase
    end
    // sequencer state and registered reset outputs; busy tracks the core reset
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state  <= HOLD;
            cnt    <= '0;
            bus_q  <= 1'b0;
            core_q <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bus_q  <= bus_nxt;
            core_q <= core_nxt;
            busy_q <= ~core_nxt;
        end
    end
    // latch the highest-priority requester; only the hard reset clears the cause
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) cause_q <= 2'b00;
        else if (req) cause_q <= wdog_rst_req ? 2'b01 : ndm_rst_req ? 2'b10 : 2'b11;
    end
    assign bus_rst_n  = test_mode ? ~rst_a : bus_q;
    assign core_rst_n = test_mode ? ~rst_a : core_q;
    assign rst_busy   = test_mode ? rst_a : busy_q;
    assign rst_cause  = cause_q;
endmodule

// File: tb/tb_e203_subsys_rst_seq.sv
// tb_e203_subsys_rst_seq: scoreboard bench against an edges-since-restart reference model
module tb_e203_subsys_rst_seq;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    typedef struct packed {
        logic       bus;
        logic       core;
        logic       busy;
        logic [1:0] cause;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       test_mode = 1'b0;
    logic       wdog = 1'b0;
    logic       ndm = 1'b0;
    logic       sw = 1'b0;
    logic       bus_rst_n, core_rst_n, rst_busy;
    logic [1:0] rst_cause;
    exp_t       q[$];
    event       chk_now;
    int         n_chk = 0;
    int         n_pass = 0;
    int         since = 0;
    logic [1:0] m_cause = 2'b00;

    e203_subsys_rst_seq #(.HOLD_CYC(HOLD), .STAGE_GAP(GAP), .CNT_W(5)) dut (
        .clk(clk), .rst_a(rst_a), .test_mode(test_mode),
        .wdog_rst_req(wdog), .ndm_rst_req(ndm), .sw_rst_req(sw),
        .bus_rst_n(bus_rst_n), .core_rst_n(core_rst_n),
        .rst_cause(rst_cause), .rst_busy(rst_busy)
    );

    always #5 clk = ~clk;

    // expected outputs: resets release a fixed number of edges after the last restart event
    function automatic exp_t model();
        exp_t e;
        logic core_rel;
        core_rel = !rst_a && since >= HOLD + GAP;
        e.bus    = test_mode ? !rst_a : (!rst_a && since >= HOLD);
        e.core   = test_mode ? !rst_a : core_rel;
        e.busy   = test_mode ? rst_a : !core_rel;
        e.cause  = m_cause;
        return e;
    endfunction

    task automatic cmp(input string name, input logic act, input logic req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    endtask

    // monitor: pop every pending expectation whenever outputs are sampled
    initial forever begin
        @(negedge clk or chk_now);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("bus_rst_n", bus_rst_n, e.bus);
            cmp("core_rst_n", core_rst_n, e.core);
            cmp("rst_busy", rst_busy, e.busy);
            n_chk++;
            if (rst_cause === e.cause) n_pass++;
            else $display("FAIL rst_cause at %0t: got %b expected %b", $time, rst_cause, e.cause);
        end
    end

    task automatic step(input logic w, input logic n, input logic s, input logic tm, input logic ra);
        @(negedge clk);
        #2;
        wdog = w; ndm = n; sw = s; test_mode = tm; rst_a = ra;
        if (ra) begin
            since = 0;
            m_cause = 2'b00;
        end
        q.push_back(model());
        #1 -> chk_now;
        @(posedge clk);
        if (!ra) begin
            if (w | n | s) begin
                since = 0;
                m_cause = w ? 2'b01 : n ? 2'b10 : 2'b11;
            end else if (since < 1000) since++;
        end
        q.push_back(model());
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_a = 1'b1;
        #1 q.push_back(model());
        -> chk_now;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        idle(39);
        step(1, 0, 0, 0, 0);
        idle(25);
        for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0);
        idle(25);
        step(0, 0, 1, 0, 0);
        idle(17);
        step(0, 1, 1, 0, 0);
        idle(25);
        step(0, 0, 1, 0, 0);
        idle(15);
        step(1, 1, 1, 0, 0);
        idle(25);
        idle(10);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(25);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        idle(25);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 119) == 0, $urandom_range(0, 119) == 0,
                 $urandom_range(0, 119) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 199) == 0);
        idle(2);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/e203_subsys_rst_seq.md
# e203_subsys_rst_seq

Reset sequencer that sits directly downstream of the subsystem reset synchronizer. It takes the synchronized system reset plus three in-band reset requests: watchdog, debug non-debug-module reset (ndmreset), and software. From these it generates two staged, registered active-low resets: bus/peripheral first, core last. Each stage is held for a programmable number of `clk` cycles, and the block records the cause of the most recent reset.

## Interface
Parameters:
- `HOLD_CYC`, default 16: cycles both resets stay asserted after the last reset condition clears; legal range ≥ 2.
- `STAGE_GAP`, default 4: cycles between `bus_rst_n` release and `core_rst_n` release; legal range ≥ 1.
- `CNT_W`, default 5: counter width; must satisfy 2^CNT_W > max(`HOLD_CYC`, `STAGE_GAP`).

Ports:
- `clk` in 1: subsystem clock.
- `rst_a` in 1: reset, asynchronous assert, active-high. Deassertion is already synchronous to `clk`.
- `test_mode` in 1: DFT bypass.
- `wdog_rst_req` in 1: watchdog reset request, level, sampled on `clk`.
- `ndm_rst_req` in 1: debug ndmreset request, level, sampled on `clk`.
- `sw_rst_req` in 1: software reset request; a single-cycle pulse suffices.
- `bus_rst_n` out 1: bus/peripheral reset, active-low, registered.
- `core_rst_n` out 1: core reset, active-low, registered.
- `rst_cause` out 2: cause of the last reset. 00 = POR/`rst_a`, 01 = watchdog, 10 = ndm, 11 = software.
- `rst_busy` out 1: high while any reset output is asserted.

## Operation
- FSM states: HOLD, BUS_REL, RUN. There is one counter `cnt` of width `CNT_W`.
- Define `req = wdog_rst_req | ndm_rst_req | sw_rst_req`.
- `rst_a` high, asynchronously: state = HOLD, `cnt` = 0, `bus_rst_n` = 0, `core_rst_n` = 0, `rst_cause` = 00, `rst_busy` = 1.
- In HOLD:
  - If `req`: `cnt` ← 0 and the state stays HOLD. A level request therefore holds reset indefinitely.
  - Else if `cnt` == `HOLD_CYC`−1: go to BUS_REL, `cnt` ← 0, `bus_rst_n` ← 1.
  - Else: `cnt` ← `cnt`+1.
- In BUS_REL:
  - If `req`: go to HOLD, `cnt` ← 0, `bus_rst_n` ← 0.
  - Else if `cnt` == `STAGE_GAP`−1: go to RUN, `core_rst_n` ← 1, `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- In RUN:
  - If `req`: go to HOLD, `cnt` ← 0, and `bus_rst_n` and `core_rst_n` both ← 0 on the same edge.
  - Else: hold.
- Cause capture:
  - On any edge where `req` is sampled high, in any state, `rst_cause` is updated.
  - Priority when requests are simultaneous: watchdog (01) > ndm (10) > sw (11).
  - `rst_cause` is otherwise stable and is not cleared by request-driven resets; only `rst_a` clears it to 00.
- `rst_busy` is registered and equals ~`core_rst_n` at all times outside test mode.
- Test mode (`test_mode` = 1), purely combinational override:
  - `bus_rst_n` = `core_rst_n` = ~`rst_a`, `rst_busy` = `rst_a`.
  - The FSM keeps running internally, but its outputs are masked.
- `cnt` never exceeds max(`HOLD_CYC`, `STAGE_GAP`)−1. There is no wrap-around path.

## Timing
- Edge numbering: E1 is the first `clk` rising edge with `rst_a` low.
- With no requests, after `rst_a` deasserts:
  - `bus_rst_n` rises after edge E(`HOLD_CYC`).
  - `core_rst_n` and `rst_busy` transition after edge E(`HOLD_CYC`+`STAGE_GAP`).
  - With the defaults, `bus_rst_n` rises after E16 and `core_rst_n` after E20.
- A request sampled high at edge Ek in BUS_REL or RUN: the affected outputs go low after Ek. Latency is 1 edge and glitch-free (flop outputs).
- A request deasserted (last sampled high) at edge Ek: `bus_rst_n` rises after E(k+`HOLD_CYC`) and `core_rst_n` after E(k+`HOLD_CYC`+`STAGE_GAP`).
- `rst_a` asserting mid-sequence forces the reset values immediately, with no clock needed.
- A request on the exact edge where the counter would expire wins: the state stays in, or returns to, HOLD.

## Test plan
- Power-on, defaults:
  - Stimulus: `rst_a` high for 3 cycles, then low, no requests.
  - Required: `bus_rst_n` = 0 through E16 and 1 after E16; `core_rst_n` = 1 after E20; `rst_cause` = 00; `rst_busy` falls after E20.
- Watchdog in RUN:
  - Stimulus: `wdog_rst_req` pulsed for 1 cycle at E40.
  - Required: both resets go to 0 after E40; `rst_cause` = 01; `bus_rst_n` rises after E56; `core_rst_n` rises after E60.
- Held ndm request:
  - Stimulus: `ndm_rst_req` high from E40 through E99.
  - Required: resets stay low through E99 + 16; `bus_rst_n` rises after E115; `core_rst_n` rises after E119; `rst_cause` = 10.
- Simultaneous requests and stage interrupt:
  - Stimulus: `sw_rst_req` and `ndm_rst_req` together during BUS_REL (E18).
  - Required: `bus_rst_n` drops after E18; `core_rst_n` never rises; `rst_cause` = 10; release times recompute from E18.
- Async reset mid-sequence:
  - Stimulus: `rst_a` pulsed at E10 + ½ cycle.
  - Required: outputs go low immediately; `rst_cause` = 00; the sequence restarts from the new E1.
- Test mode:
  - Stimulus: `test_mode` = 1, toggle `rst_a`, and pulse `wdog_rst_req`.
  - Required: `bus_rst_n` = `core_rst_n` = ~`rst_a` combinationally; the request has no visible effect on these outputs.
